// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle for pipe_stage_buf: upstream/downstream valid-ready pairs,
// flush and occupancy. The slave modport is the buffer's view.
interface pipe_stage_buf_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic          flush_i;
    logic [CW-1:0] count_o;

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i, flush_i,
        output in_ready_o, out_valid_o, out_data_o, count_o
    );

    modport master (
        output in_valid_i, in_data_i, out_ready_i, flush_i,
        input  in_ready_o, out_valid_o, out_data_o, count_o
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Registered FIFO pipeline stage (DEPTH entries, 1-cycle latency, flush).
// Define PIPE_OUT_MASK_EN to force out_data_o to zero whenever out_valid_o is low.
module pipe_stage_buf #(
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_buf_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full;
    logic          in_ready;
    logic          out_valid;
    logic          push;
    logic          pop;
    logic [DW-1:0] head;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (cnt_q == CW'(DEPTH));
    assign out_valid = (cnt_q != '0);

    // A single entry can only sustain full rate if the pop frees the slot
    // in the same cycle; deeper buffers keep in_ready purely registered.
    generate
        if (DEPTH == 1) begin : g_ready_d1
            assign in_ready = !full || bus.out_ready_i;
        end else begin : g_ready_dn
            assign in_ready = !full;
        end
    endgenerate

    assign push = bus.in_valid_i && in_ready;
    assign pop  = out_valid && bus.out_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push && !bus.flush_i && !rst) begin
            mem_q[wr_ptr_q] <= bus.in_data_i;
        end
    end

    assign head = mem_q[rd_ptr_q];

`ifdef PIPE_OUT_MASK_EN
    assign bus.out_data_o = head & {DW{out_valid}};
`else
    assign bus.out_data_o = head;
`endif

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.count_o     = cnt_q;
endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DW, default 32: payload width in bits, legal range 1..256.
REQ-002 SHALL have parameter DEPTH, default 2: entry count, legal range 1..8, not restricted to powers of two.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid_i, input, 1 bit: upstream payload valid.
REQ-006 SHALL have port in_ready_o, output, 1 bit: stage can accept.
REQ-007 SHALL have port in_data_i, input, DW bits: upstream payload.
REQ-008 SHALL have port out_valid_o, output, 1 bit: head entry valid.
REQ-009 SHALL have port out_ready_i, input, 1 bit: downstream can accept.
REQ-010 SHALL have port out_data_o, output, DW bits: head-entry payload.
REQ-011 SHALL have port flush_i, input, 1 bit: discard all held entries.
REQ-012 SHALL have port count_o, output, $clog2(DEPTH+1) bits: occupied entries.

Function
REQ-013 SHALL define push = in_valid_i && in_ready_o and pop = out_valid_o && out_ready_i.
REQ-014 SHALL store entries in FIFO order, circular write/read pointers wrapping from DEPTH-1 to 0.
REQ-015 SHALL drive out_valid_o = (count_o != 0) and out_data_o = entry at read pointer.
REQ-016 SHALL give latency of exactly 1 cycle: data pushed at edge N is visible on out_data_o after edge N; no combinational in->out data path.
REQ-017 SHALL, when DEPTH == 1, drive in_ready_o = !full || out_ready_i (simultaneous pop and push when full, sustaining 1 transfer/cycle).
REQ-018 SHALL, when DEPTH >= 2, drive in_ready_o = !full from state only (no combinational path from out_ready_i), sustaining 1 transfer/cycle in steady state.
REQ-019 SHALL update count: +1 on push only, -1 on pop only, unchanged on push and pop together or neither.
REQ-020 SHALL, when empty and push occurs with out_ready_i high, not bypass: the entry appears next cycle.
REQ-021 SHALL, when flush_i is high, set count_o to 0 and both pointers to 0 at the next edge; any push in that cycle is discarded; a pop in that cycle counts as completed downstream.
REQ-022 SHALL keep in_ready_o driven per REQ-017/018 during flush (a discarded push is legal, not an error).
REQ-023 SHALL never overflow or underflow: push when full (DEPTH >= 2) cannot occur; pop when empty cannot occur.
REQ-024 SHALL hold out_data_o stable while out_valid_o && !out_ready_i, absent flush.

Reset
REQ-025 SHALL, with rst high at an edge, set count_o = 0, pointers = 0, out_valid_o = 0; rst overrides push, pop and flush in the same cycle.
REQ-026 SHALL drive in_ready_o = 1 in the cycle after reset.
REQ-027 SHALL not reset payload storage; reset mid-stream drops all held entries.

Configuration
REQ-028 SHALL honour macro PIPE_OUT_MASK_EN: when defined, out_data_o = head payload AND-masked with {DW{out_valid_o}} (zero whenever invalid, including after reset).
REQ-029 SHALL, when PIPE_OUT_MASK_EN is undefined, drive out_data_o unmasked; its value when out_valid_o = 0 is don't-care.

Verification
REQ-030 SHALL cover, DEPTH=2, DW=32, out_ready_i=1: push 0x11,0x22,0x33 on consecutive cycles -> outputs 0x11,0x22,0x33 on the following three cycles, count_o steady at 1.
REQ-031 SHALL cover, DEPTH=2, out_ready_i=0: push 0xA,0xB -> count_o=2, in_ready_o=0; then out_ready_i=1 -> 0xA then 0xB popped, in_ready_o=1 the cycle after the first pop.
REQ-032 SHALL cover, DEPTH=1, full with 0x5, out_ready_i=1, push 0x6 -> 0x5 popped and 0x6 held next cycle, count_o stays 1.
REQ-033 SHALL cover, DEPTH=3: hold 2 entries, assert flush_i with simultaneous push 0x77 -> count_o=0, out_valid_o=0 next cycle; 0x77 never appears.
REQ-034 SHALL cover, DEPTH=3: 10 push/pop cycles with random back-pressure -> pointer wrap with order preserved; rst mid-stream -> count_o=0, out_valid_o=0 next cycle; with PIPE_OUT_MASK_EN, out_data_o=0.
